stopwatch_core: RTL and testbench

Tick-driven stopwatch counter for the Swiss timer. Consumes the one-cycle `tick` pulse from the clock divider (one pulse per 1,000,000 `clock` cycles, i.e. one centisecond) and the debounced front-panel command pulses. Accumulates elapsed time as BCD MM:SS.cc and drives the six-digit display path with a live or lap-frozen value.

---
 rtl/stopwatch_pkg.sv | 46 ++++
 rtl/stopwatch_digit.sv | 36 +++
 rtl/stopwatch_core.sv | 115 +++++++++++
 tb/tb_stopwatch_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: state encoding, BCD digit
// limits and the layout of the six-digit display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int DISP_W     = NUM_DIGITS * DIGIT_W;

  localparam logic [3:0] DIGIT_MAX_NINE = 4'd9;
  localparam logic [3:0] DIGIT_MAX_FIVE = 4'd5;

  localparam int CS_O_LSB  = 0;
  localparam int CS_T_LSB  = 4;
  localparam int SEC_O_LSB = 8;
  localparam int SEC_T_LSB = 12;
  localparam int MIN_O_LSB = 16;
  localparam int MIN_T_LSB = 20;

  // Digit index 0 is centisecond ones, index 5 is minute tens.
  function automatic int digitLsb(input int idx);
    case (idx)
      0:       return CS_O_LSB;
      1:       return CS_T_LSB;
      2:       return SEC_O_LSB;
      3:       return SEC_T_LSB;
      4:       return MIN_O_LSB;
      default: return MIN_T_LSB;
    endcase
  endfunction

  function automatic logic [3:0] digitLimit(input int idx, input int minTensMax);
    case (idx)
      3:       return DIGIT_MAX_FIVE;
      5:       return 4'(minTensMax);
      default: return DIGIT_MAX_NINE;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD counter digit that wraps at MAX; carry_o tells the next digit to step.
module stopwatch_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic       hold_i,
  output logic [3:0] q_o,
  output logic       carry_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (inc_i && !hold_i) begin
      q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = inc_i && (q_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Tick-driven MM:SS.cc stopwatch: command FSM, six chained BCD digits, lap
// capture register and the registered display word.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN_TENS = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic              start_stop_i,
  input  logic              lap_i,
  input  logic              clear_i,
  output logic [DISP_W-1:0] disp_digits_o,
  output logic              running_o,
  output logic              lap_active_o,
  output logic              overflow_o
);

  state_e            state_q, state_d;
  logic [DISP_W-1:0] liveCount;
  logic [DISP_W-1:0] lapCount_q, lapCount_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              overflow_q, overflow_d;
  logic [NUM_DIGITS-1:0] digitInc, digitCarry, digitAtMax;
  logic              countEnable, saturated, clearCount, captureLap;

  // Counting depends only on the registered state, never on same-cycle commands.
  assign countEnable = tick_i && ((state_q == RUN) || (state_q == LAP));
  assign saturated   = &digitAtMax;
  assign digitInc    = {digitCarry[NUM_DIGITS-2:0], countEnable};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
    localparam logic [3:0] LIMIT = digitLimit(i, MAX_MIN_TENS);
    logic [3:0] digitQ;

    stopwatch_digit #(.MAX(LIMIT)) uDigit (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .inc_i   (digitInc[i]),
      .clr_i   (clearCount),
      .hold_i  (saturated),
      .q_o     (digitQ),
      .carry_o (digitCarry[i])
    );

    assign liveCount[digitLsb(i) +: DIGIT_W] = digitQ;
    assign digitAtMax[i] = (digitQ == LIMIT);
  end

  // start_stop outranks lap, which outranks clear; a dropped command never acts.
  always_comb begin
    state_d    = state_q;
    clearCount = 1'b0;
    captureLap = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop_i) state_d = RUN;
      end
      RUN: begin
        if (start_stop_i) begin
          state_d = PAUSE;
        end else if (lap_i) begin
          state_d    = LAP;
          captureLap = 1'b1;
        end
      end
      LAP: begin
        if (start_stop_i)  state_d = PAUSE;
        else if (lap_i)    state_d = RUN;
      end
      PAUSE: begin
        if (start_stop_i) begin
          state_d = RUN;
        end else if (!lap_i && clear_i) begin
          state_d    = IDLE;
          clearCount = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A carry out of the top digit only happens when every digit sits at its limit.
  always_comb begin
    overflow_d = overflow_q;
    if (clearCount) begin
      overflow_d = 1'b0;
    end else if (digitCarry[NUM_DIGITS-1]) begin
      overflow_d = 1'b1;
    end
    lapCount_d = captureLap ? liveCount : lapCount_q;
    disp_d     = (state_q == LAP) ? lapCount_q : liveCount;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      lapCount_q <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lapCount_q <= lapCount_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
    end
  end

  assign disp_digits_o = disp_q;
  assign running_o     = (state_q == RUN) || (state_q == LAP);
  assign lap_active_o  = (state_q == LAP);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a centisecond-integer reference model
// checked every cycle, plus literal BCD expectations at key points.
module tb_stopwatch_core;

  localparam int MAX_MIN_TENS = 0;
  localparam int MAX_CS = ((MAX_MIN_TENS * 10 + 9) * 60 + 59) * 100 + 99;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        startStop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] dispDigits;
  logic        running;
  logic        lapActive;
  logic        overflow;

  int assertCount = 0;
  int failCount   = 0;
  bit checkOn     = 1'b0;

  int mCount = 0;
  int mLap   = 0;
  int mMode  = M_IDLE;
  bit mOvf   = 1'b0;
  int mDisp  = 0;

  stopwatch_core #(.MAX_MIN_TENS(MAX_MIN_TENS)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .tick_i        (tick),
    .start_stop_i  (startStop),
    .lap_i         (lap),
    .clear_i       (clear),
    .disp_digits_o (dispDigits),
    .running_o     (running),
    .lap_active_o  (lapActive),
    .overflow_o    (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] toBcd(input int cs);
    int secs;
    int mins;
    secs = (cs / 100) % 60;
    mins = cs / 6000;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  // Reference model: elapsed time as a plain centisecond count.
  always @(posedge clock or posedge reset) begin : model
    int nCount;
    int nLap;
    int nMode;
    bit nOvf;
    if (reset) begin
      mCount <= 0;
      mLap   <= 0;
      mMode  <= M_IDLE;
      mOvf   <= 1'b0;
      mDisp  <= 0;
    end else begin
      nCount = mCount;
      nLap   = mLap;
      nMode  = mMode;
      nOvf   = mOvf;
      if (tick && (mMode == M_RUN || mMode == M_LAP)) begin
        if (mCount == MAX_CS) nOvf = 1'b1;
        else                  nCount = mCount + 1;
      end
      if (startStop) begin
        nMode = (mMode == M_RUN || mMode == M_LAP) ? M_PAUSE : M_RUN;
      end else if (lap) begin
        if (mMode == M_RUN) begin
          nMode = M_LAP;
          nLap  = mCount;
        end else if (mMode == M_LAP) begin
          nMode = M_RUN;
        end
      end else if (clear && mMode == M_PAUSE) begin
        nMode  = M_IDLE;
        nCount = 0;
        nOvf   = 1'b0;
      end
      mDisp  <= (mMode == M_LAP) ? mLap : mCount;
      mCount <= nCount;
      mLap   <= nLap;
      mMode  <= nMode;
      mOvf   <= nOvf;
    end
  end

  task automatic checkOutput(input string name, input logic [23:0] actual,
                             input logic [23:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checkOn) begin
      checkOutput("modelDisp", dispDigits, toBcd(mDisp));
      checkOutput("modelRunning", 24'(running), 24'(mMode == M_RUN || mMode == M_LAP));
      checkOutput("modelLapActive", 24'(lapActive), 24'(mMode == M_LAP));
      checkOutput("modelOverflow", 24'(overflow), 24'(mOvf));
    end
  end

  // Holds the given command/tick levels for n sampled edges.
  task automatic applyStimulus(input bit s, input bit l, input bit c, input bit t,
                               input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      startStop = s;
      lap       = l;
      clear     = c;
      tick      = t;
    end
  endtask

  task automatic idleThenSettle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clock);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset   = 1'b0;
    checkOn = 1'b1;
    checkOutput("resetDisp", dispDigits, 24'h000000);
    checkOutput("resetRunning", 24'(running), 24'd0);
    checkOutput("resetLapActive", 24'(lapActive), 24'd0);
    checkOutput("resetOverflow", 24'(overflow), 24'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 150);
    idleThenSettle();
    checkOutput("count150", dispDigits, 24'h000150);
    checkOutput("count150Running", 24'(running), 24'd1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5849);
    idleThenSettle();
    checkOutput("preload5999", dispDigits, 24'h005999);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    idleThenSettle();
    checkOutput("rippleToMinute", dispDigits, 24'h010000);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    idleThenSettle();
    checkOutput("clearFromPause", dispDigits, 24'h000000);
    checkOutput("clearIdleRunning", 24'(running), 24'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
    idleThenSettle();
    checkOutput("tickStartFromIdle", dispDigits, 24'h000000);
    checkOutput("tickStartRunning", 24'(running), 24'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
    idleThenSettle();
    checkOutput("tickStopFromRun", dispDigits, 24'h000001);
    checkOutput("tickStopRunning", 24'(running), 24'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 41);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10);
    idleThenSettle();
    checkOutput("lapFrozen", dispDigits, 24'h000042);
    checkOutput("lapActiveHigh", 24'(lapActive), 24'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    idleThenSettle();
    checkOutput("lapReleased", dispDigits, 24'h000052);
    checkOutput("lapActiveLow", 24'(lapActive), 24'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    idleThenSettle();
    checkOutput("priorityKeepsCount", dispDigits, 24'h000052);
    checkOutput("priorityPaused", 24'(running), 24'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    idleThenSettle();
    checkOutput("secondClear", dispDigits, 24'h000000);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MAX_CS + 3);
    idleThenSettle();
    checkOutput("saturatedDisp", dispDigits, 24'h095999);
    checkOutput("saturatedOverflow", 24'(overflow), 24'd1);
    checkOutput("saturatedRunning", 24'(running), 24'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    idleThenSettle();
    checkOutput("clearInRunIgnored", dispDigits, 24'h095999);
    checkOutput("clearInRunOverflow", 24'(overflow), 24'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    idleThenSettle();
    checkOutput("overflowCleared", 24'(overflow), 24'd0);
    checkOutput("overflowClearDisp", dispDigits, 24'h000000);
    checkOutput("overflowClearIdle", 24'(running), 24'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 20);
    @(posedge clock);
    #2;
    reset     = 1'b1;
    tick      = 1'b0;
    startStop = 1'b0;
    lap       = 1'b0;
    clear     = 1'b0;
    #1;
    checkOutput("asyncResetDisp", dispDigits, 24'h000000);
    checkOutput("asyncResetRunning", 24'(running), 24'd0);
    checkOutput("asyncResetLapActive", 24'(lapActive), 24'd0);
    checkOutput("asyncResetOverflow", 24'(overflow), 24'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5);
    idleThenSettle();
    checkOutput("restartAfterReset", dispDigits, 24'h000005);

    @(negedge clock);
    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
